// File: rtl/noc_flit_pkg.sv
// Shared definitions for the mesh flit format and the injector FSM.
//   - flit type codes carried in the two top bits of every flit
//   - bit positions of the head and body/tail fields
//   - mesh node-id width
//   - injector FSM state encoding
package noc_flit_pkg;

    localparam int NODE_W = 2;
    localparam int SEQ_W  = 8;
    localparam int IDX_W  = 6;

    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_TAIL = 2'b10;

    // Head flit fields
    localparam int DEST_LSB = 12;
    localparam int SRC_LSB  = 10;
    localparam int HSEQ_LSB = 2;

    // Body/tail flit fields
    localparam int BSEQ_LSB = 6;
    localparam int IDX_LSB  = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } inj_state_t;

endpackage

// File: rtl/flit_fifo.sv
// Small synchronous flit FIFO.
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset (empties the FIFO)
//   push   write din (ignored while full)
//   din    flit to write
//   pop    remove the head entry (ignored while empty)
//   dout   head entry, combinational from storage; 0 while empty
//   full   FIFO_DEPTH entries held
//   empty  no entries held
module flit_fifo #(
    parameter int FLIT_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [FLIT_W-1:0] din,
    input  logic              pop,
    output logic [FLIT_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    // One extra MSB on each pointer distinguishes full from empty
    // when the address bits are equal.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // Storage is not reset; an empty FIFO masks stale contents to zero.
    assign dout = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lfsr_flit_injector.sv
// Pseudo-random packet source for one mesh node.
// Samples the node LFSR every cycle; when idle and the value qualifies it
// generates a PKT_LEN-flit packet (head/body.../tail) into a small FIFO that
// feeds the router injection port over valid/ready.
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   en          allows new packets to start (in-flight packet always finishes)
//   rnd         4-bit LFSR value
//   flit_out    flit at the FIFO head
//   flit_valid  flit_out is valid
//   flit_ready  router accepts flit_out
//   busy        packet being generated or FIFO non-empty
//   pkt_cnt     packets fully pushed, wraps at 2^16
module lfsr_flit_injector
    import noc_flit_pkg::*;
#(
    parameter int SRC_ID     = 0,
    parameter int FLIT_W     = 16,
    parameter int PKT_LEN    = 3,
    parameter int INJ_THRESH = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [3:0]        rnd,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic              busy,
    output logic [15:0]       pkt_cnt
);

    inj_state_t        state_reg;
    logic [NODE_W-1:0] dest_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [SEQ_W-1:0]  seq_reg;
    logic [15:0]       pkt_cnt_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              start;
    logic              is_tail;
    logic [FLIT_W-1:0] flit_next;

    // Threshold compared at 5 bits so INJ_THRESH=16 admits every value and
    // INJ_THRESH=0 admits none.
    assign start   = en && ({1'b0, rnd} < 5'(INJ_THRESH)) &&
                     (rnd[1:0] != NODE_W'(SRC_ID));
    assign is_tail = (idx_reg == IDX_W'(PKT_LEN - 1));
    // Gated on registered full: a same-cycle pop never makes room.
    assign push    = (state_reg == ST_GEN) && !fifo_full;

    always_comb begin
        flit_next = '0;
        if (idx_reg == '0) begin
            flit_next[FLIT_W-1 -: 2]         = FT_HEAD;
            flit_next[DEST_LSB +: NODE_W]    = dest_reg;
            flit_next[SRC_LSB +: NODE_W]     = NODE_W'(SRC_ID);
            flit_next[HSEQ_LSB +: SEQ_W]     = seq_reg;
        end else begin
            flit_next[FLIT_W-1 -: 2]         = is_tail ? FT_TAIL : FT_BODY;
            flit_next[BSEQ_LSB +: SEQ_W]     = seq_reg;
            flit_next[IDX_LSB +: IDX_W]      = idx_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            dest_reg    <= '0;
            idx_reg     <= '0;
            seq_reg     <= '0;
            pkt_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        dest_reg  <= rnd[1:0];
                        idx_reg   <= '0;
                        state_reg <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    if (push) begin
                        if (is_tail) begin
                            idx_reg     <= '0;
                            seq_reg     <= seq_reg + 1'b1;
                            pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
                            state_reg   <= ST_IDLE;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    flit_fifo #(
        .FLIT_W     (FLIT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (flit_next),
        .pop   (flit_ready),
        .dout  (flit_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign flit_valid = !fifo_empty;
    assign busy       = (state_reg == ST_GEN) || !fifo_empty;
    assign pkt_cnt    = pkt_cnt_reg;

endmodule

// File: tb/tb_lfsr_flit_injector.sv
// Scoreboard bench for lfsr_flit_injector with default parameters.
module tb_lfsr_flit_injector;

    localparam int          DEPTH  = 4;
    localparam int          LEN    = 3;
    localparam int          THRESH = 4;
    localparam logic [1:0]  SRC    = 2'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  rnd;
    logic [15:0] flit_out;
    logic        flit_valid;
    logic        flit_ready;
    logic        busy;
    logic [15:0] pkt_cnt;

    lfsr_flit_injector dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rnd        (rnd),
        .flit_out   (flit_out),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .busy       (busy),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side model of the injector
    bit          m_gen;
    int          m_idx;
    int          m_count;
    logic [1:0]  m_dest;
    logic [7:0]  m_seq;
    logic [15:0] m_pkt;
    logic [15:0] exp_q[$];
    logic [15:0] got_log[$];
    bit          prev_stall;
    logic [15:0] prev_flit;
    logic [3:0]  lfsr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk_head(input logic [1:0] d, input logic [7:0] s);
        return {2'b01, d, SRC, s, 2'b00};
    endfunction

    function automatic logic [15:0] mk_bt(input logic tail, input logic [7:0] s, input int i);
        logic [5:0] idx6;
        idx6 = 6'(i);
        return {(tail ? 2'b10 : 2'b00), s, idx6};
    endfunction

    task automatic model_clear();
        m_gen      = 1'b0;
        m_idx      = 0;
        m_count    = 0;
        m_dest     = 2'd0;
        m_seq      = 8'd0;
        m_pkt      = 16'd0;
        prev_stall = 1'b0;
        exp_q.delete();
    endtask

    // One clock: drive inputs at negedge, check outputs, then advance model
    // to what the coming posedge should produce.
    task automatic tick(input logic e, input logic [3:0] r, input logic rdy);
        bit do_push;
        bit do_pop;
        @(negedge clk);
        en         = e;
        rnd        = r;
        flit_ready = rdy;
        check_eq("valid", 32'(flit_valid), 32'(m_count != 0));
        check_eq("busy", 32'(busy), 32'(m_gen || (m_count != 0)));
        check_eq("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
        if (prev_stall) check_eq("stable", 32'(flit_out), 32'(prev_flit));
        if (flit_valid && rdy) begin
            got_log.push_back(flit_out);
            if (exp_q.size() != 0) check_eq("flit", 32'(flit_out), 32'(exp_q.pop_front()));
        end
        prev_stall = flit_valid && !rdy;
        prev_flit  = flit_out;

        do_push = m_gen && (m_count != DEPTH);
        do_pop  = (m_count != 0) && rdy;
        if (!m_gen) begin
            if (e && ({1'b0, r} < 5'(THRESH)) && (r[1:0] != SRC)) begin
                m_gen  = 1'b1;
                m_idx  = 0;
                m_dest = r[1:0];
            end
        end else if (do_push) begin
            if (m_idx == 0) exp_q.push_back(mk_head(m_dest, m_seq));
            else            exp_q.push_back(mk_bt(m_idx == LEN - 1, m_seq, m_idx));
            if (m_idx == LEN - 1) begin
                m_gen = 1'b0;
                m_seq = m_seq + 8'd1;
                m_pkt = m_pkt + 16'd1;
            end else begin
                m_idx++;
            end
        end
        m_count = m_count + int'(do_push) - int'(do_pop);
    endtask

    // Asynchronous reset pulse lasting one clock.
    task automatic do_reset();
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("rst_valid", 32'(flit_valid), 32'd0);
        check_eq("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_flit", 32'(flit_out), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        en         = 1'b0;
        rnd        = 4'h9;
        flit_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_eq("init_valid", 32'(flit_valid), 32'd0);
        check_eq("init_busy", 32'(busy), 32'd0);
        check_eq("init_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check_eq("init_flit", 32'(flit_out), 32'd0);
        rst = 1'b1;

        // Single packet to node 2, ready held high
        got_log.delete();
        tick(1'b1, 4'h2, 1'b1);
        repeat (8) tick(1'b1, 4'h9, 1'b1);
        check_eq("t1_count", 32'(got_log.size()), 32'd3);
        check_eq("t1_head", 32'(got_log[0]), 32'h6000);
        check_eq("t1_body", 32'(got_log[1]), 32'h0001);
        check_eq("t1_tail", 32'(got_log[2]), 32'h8002);
        check_eq("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd0);

        // No injection: dest equals own id, then value above threshold
        repeat (20) tick(1'b1, 4'h0, 1'b1);
        repeat (20) tick(1'b1, 4'hA, 1'b1);
        check_eq("t2_count", 32'(got_log.size()), 32'd3);
        check_eq("t2_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Reset mid-packet, after head and body are in the FIFO
        tick(1'b1, 4'h1, 1'b0);
        tick(1'b1, 4'h9, 1'b0);
        tick(1'b1, 4'h9, 1'b0);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        do_reset();

        // Backpressure fill, then drain in order
        got_log.delete();
        repeat (12) tick(1'b1, 4'h1, 1'b0);
        check_eq("t3_busy_stall", 32'(busy), 32'd1);
        check_eq("t3_valid_stall", 32'(flit_valid), 32'd1);
        check_eq("t3_flit_stall", 32'(flit_out), 32'h5000);
        repeat (12) tick(1'b0, 4'h9, 1'b1);
        check_eq("t3_count", 32'(got_log.size()), 32'd6);
        check_eq("t3_f0", 32'(got_log[0]), 32'h5000);
        check_eq("t3_f1", 32'(got_log[1]), 32'h0001);
        check_eq("t3_f2", 32'(got_log[2]), 32'h8002);
        check_eq("t3_f3", 32'(got_log[3]), 32'h5004);
        check_eq("t3_f4", 32'(got_log[4]), 32'h0041);
        check_eq("t3_f5", 32'(got_log[5]), 32'h8042);
        check_eq("t3_pkt_cnt", 32'(pkt_cnt), 32'd2);

        // en dropped right after the head push
        got_log.delete();
        tick(1'b1, 4'h1, 1'b1);
        tick(1'b0, 4'h1, 1'b1);
        repeat (15) tick(1'b0, 4'h1, 1'b1);
        check_eq("t5_count", 32'(got_log.size()), 32'd3);
        check_eq("t5_head", 32'(got_log[0]), 32'h5008);
        check_eq("t5_pkt_cnt", 32'(pkt_cnt), 32'd3);
        check_eq("t5_busy", 32'(busy), 32'd0);

        // Random LFSR traffic with random backpressure
        lfsr = 4'h0;
        for (int i = 0; i < 10000; i++) begin
            lfsr = {lfsr[2:0], ~(lfsr[3] ^ lfsr[2])};
            tick(1'b1, lfsr, 1'($urandom_range(0, 3) != 0));
        end
        repeat (40) tick(1'b0, 4'h9, 1'b1);
        check_eq("rand_leftover", 32'(exp_q.size()), 32'd0);
        check_eq("rand_busy", 32'(busy), 32'd0);
        check_eq("rand_valid", 32'(flit_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
